// File: rtl/rf_pkg.sv
// Shared types for the register-file write arbiter: request record and r0 constant.
// Pure declarations; no timing or flow control of its own.
package rf_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] R0 = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] wr;
    logic [DATA_W-1:0] wd;
  } rf_wreq_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Sync FIFO of rf_wreq_t; head visible the cycle after push, pop at posedge.
// Caller gates push on !full; push+pop together is accepted even when full.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  rf_wreq_t               i_dat,
  output rf_wreq_t               o_dat,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  rf_wreq_t        r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_count = r_wptr - r_rptr;
  assign o_dat   = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push && (!w_full || i_pop);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the reg-file write port between WB and buffered mult/div results; grant is same-cycle.
// WB has priority until the FIFO head starves, then wb_stall holds WB off for one cycle.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = rf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [4:0]        wb_wr,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              wb_stall,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [4:0]        md_wr,
  input  logic [DATA_W-1:0] md_wd,
  input  logic              iss_valid,
  input  logic [4:0]        iss_wr,
  input  logic [4:0]        pr1,
  input  logic [4:0]        pr2,
  input  logic [4:0]        pw,
  output logic              busy1,
  output logic              busy2,
  output logic              busyw,
  output logic              rf_write,
  output logic [4:0]        rf_wr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              proto_err
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT) + 1;
  localparam int NREG  = 1 << REG_AW;

  rf_wreq_t         w_head;
  rf_wreq_t         w_push_dat;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_wb_win;
  logic             w_head_grant;
  logic             w_head_lose;
  logic             w_iss_set;
  logic             w_iss_dup;
  logic [NREG-1:0]  w_pend_nxt;

  logic [NREG-1:0]  r_pending;
  logic [SW-1:0]    r_starve;
  logic             r_wb_stall;
  logic             r_proto_err;

  assign w_push_dat = '{wr: md_wr, wd: md_wd};
  assign md_ready   = !reset && (w_count != CW'(FIFO_DEPTH));

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (md_valid && md_ready),
    .i_pop   (w_head_grant),
    .i_dat   (w_push_dat),
    .o_dat   (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A WB aimed at r0 is not a real write, so it must not hold off the FIFO head.
  assign w_wb_win     = !reset && !r_wb_stall && wb_valid && (wb_wr != R0);
  assign w_head_grant = !reset && !w_empty && !w_wb_win;
  assign w_head_lose  = !w_empty && !w_head_grant;
  assign w_iss_set    = iss_valid && (iss_wr != R0);
  assign w_iss_dup    = w_iss_set && r_pending[iss_wr];

  always_comb begin
    rf_write = 1'b0;
    rf_wr    = w_head.wr;
    rf_wd    = w_head.wd;
    if (w_wb_win) begin
      rf_write = 1'b1;
      rf_wr    = wb_wr;
      rf_wd    = wb_wd;
    end else if (w_head_grant) begin
      rf_write = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle issue to the retiring reg stays pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_head_grant) w_pend_nxt[w_head.wr] = 1'b0;
    if (w_iss_set)    w_pend_nxt[iss_wr]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_starve    <= '0;
      r_wb_stall  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_pending   <= w_pend_nxt;
      r_proto_err <= r_proto_err | (wb_valid && r_wb_stall) | w_iss_dup;
      if (w_head_lose) begin
        if (r_starve == SW'(STARVE_LIMIT - 1)) r_wb_stall <= 1'b1;
        else                                   r_starve   <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
      if (w_head_grant) r_wb_stall <= 1'b0;
    end
  end

  assign wb_stall  = r_wb_stall;
  assign proto_err = r_proto_err;
  assign busy1     = r_pending[pr1];
  assign busy2     = r_pending[pr2];
  assign busyw     = r_pending[pw];
endmodule
